// File: rtl/ca_code.sv
// GPS L1 C/A Gold-code generator: G1/G2 10-stage LFSRs with a two-tap G2 phase selector, one chip per clock.
// Optional chip index counter and epoch flag are enabled by defining CA_CODE_EPOCH_EN.
module ca_code (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] g1_init,
    input  logic [9:0] g2_init,
    input  logic [3:0] T0,
    input  logic [3:0] T1,
`ifdef CA_CODE_EPOCH_EN
    output logic [9:0] chip_idx,
    output logic       epoch,
`endif
    output logic       chip
);

    localparam logic [9:0] ALL_ONES = 10'h3FF;
    localparam logic [9:0] LAST_IDX = 10'd1022;

    logic [9:0] g1_q, g1_d;
    logic [9:0] g2_q, g2_d;
    logic       g1_fb, g2_fb;

    // Selects G2 stage t (1..10); any other tap value contributes nothing.
    function automatic logic tap_bit(input logic [9:0] g, input logic [3:0] t);
        logic b;
        b = 1'b0;
        case (t)
            4'd1:    b = g[0];
            4'd2:    b = g[1];
            4'd3:    b = g[2];
            4'd4:    b = g[3];
            4'd5:    b = g[4];
            4'd6:    b = g[5];
            4'd7:    b = g[6];
            4'd8:    b = g[7];
            4'd9:    b = g[8];
            4'd10:   b = g[9];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    always_comb begin
        g1_fb = g1_q[2] ^ g1_q[9];
        g2_fb = g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9];
        g1_d  = {g1_q[8:0], g1_fb};
        g2_d  = {g2_q[8:0], g2_fb};
        if (rst) begin
            // An all-zero load would freeze the LFSR, so it is replaced by all ones.
            g1_d = (g1_init == 10'd0) ? ALL_ONES : g1_init;
            g2_d = (g2_init == 10'd0) ? ALL_ONES : g2_init;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        g1_q <= g1_d;
        g2_q <= g2_d;
    end

    assign chip = g1_q[9] ^ tap_bit(g2_q, T0) ^ tap_bit(g2_q, T1);

`ifdef CA_CODE_EPOCH_EN
    logic [9:0] idx_q, idx_d;

    always_comb begin
        if (rst || idx_q == LAST_IDX) begin
            idx_d = 10'd0;
        end else begin
            idx_d = idx_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        idx_q <= idx_d;
    end

    assign chip_idx = idx_q;
    assign epoch    = (idx_q == 10'd0);
`endif

endmodule

// File: tb/tb_ca_code.sv
// Self-checking bench for ca_code: table of directed chip sequences plus multi-cycle reset/period sequences.
// Epoch/index checks are compiled only when CA_CODE_EPOCH_EN is defined.
module tb_ca_code;

    logic       clk;
    logic       rst;
    logic [9:0] g1_init;
    logic [9:0] g2_init;
    logic [3:0] T0;
    logic [3:0] T1;
    logic       chip;
`ifdef CA_CODE_EPOCH_EN
    logic [9:0] chip_idx;
    logic       epoch;
`endif

    int checks = 0;
    int errors = 0;

    ca_code dut (
        .clk     (clk),
        .rst     (rst),
        .g1_init (g1_init),
        .g2_init (g2_init),
        .T0      (T0),
        .T1      (T1),
`ifdef CA_CODE_EPOCH_EN
        .chip_idx(chip_idx),
        .epoch   (epoch),
`endif
        .chip    (chip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [9:0]  g1i;
        logic [9:0]  g2i;
        logic [3:0]  t0;
        logic [3:0]  t1;
        int          len;
        logic [19:0] exp;   // first chips, MSB = chip 0
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
    endtask

    task automatic collect(input int len, output logic [19:0] got);
        got = 20'd0;
        for (int i = 0; i < len; i++) begin
            got[19-i] = chip;
            step();
        end
    endtask

    logic        seq_a [1023];
    logic [19:0] got;
    int          diff;
    int          epochs;

    initial begin
        vecs[0] = '{"prn1",        10'h3FF, 10'h3FF, 4'd2,  4'd6,  10, 20'hC8000};
        vecs[1] = '{"prn2",        10'h3FF, 10'h3FF, 4'd3,  4'd7,  10, 20'hE4000};
        vecs[2] = '{"zero_init",   10'h000, 10'h000, 4'd2,  4'd6,  10, 20'hC8000};
        vecs[3] = '{"t_equal",     10'h3FF, 10'h3FF, 4'd5,  4'd5,  20, 20'hFFC71};
        vecs[4] = '{"t_both_inv",  10'h3FF, 10'h3FF, 4'd15, 4'd15, 20, 20'hFFC71};
        vecs[5] = '{"t0_zero",     10'h3FF, 10'h3FF, 4'd0,  4'd10, 20, 20'h000C5};
        vecs[6] = '{"t0_inv11",    10'h3FF, 10'h3FF, 4'd11, 4'd10, 20, 20'h000C5};

        rst = 1'b0; g1_init = 10'h3FF; g2_init = 10'h3FF; T0 = 4'd2; T1 = 4'd6;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            g1_init = vecs[v].g1i; g2_init = vecs[v].g2i;
            T0 = vecs[v].t0; T1 = vecs[v].t1;
            do_reset(1);
            check({vecs[v].name, "_chip0"}, {31'd0, chip}, {31'd0, vecs[v].exp[19]});
`ifdef CA_CODE_EPOCH_EN
            check({vecs[v].name, "_idx0"}, {22'd0, chip_idx}, 32'd0);
            check({vecs[v].name, "_epoch0"}, {31'd0, epoch}, 32'd1);
`endif
            collect(vecs[v].len, got);
            check(vecs[v].name, {12'd0, got}, {12'd0, vecs[v].exp});
        end

        // Long reset hold stays at chip 0; inits are ignored once reset drops.
        g1_init = 10'h3FF; g2_init = 10'h3FF; T0 = 4'd2; T1 = 4'd6;
        do_reset(4);
        g1_init = 10'h155; g2_init = 10'h0AA;
        collect(10, got);
        check("reset_hold_prn1", {12'd0, got}, {12'd0, 20'hC8000});

        // Taps act combinationally: at chip 2 PRN1 gives 0, PRN2 gives 1.
        g1_init = 10'h3FF; g2_init = 10'h3FF;
        do_reset(1);
        step(); step();
        check("tap_prn1_chip2", {31'd0, chip}, 32'd0);
        T0 = 4'd3; T1 = 4'd7;
        #1;
        check("tap_prn2_chip2", {31'd0, chip}, 32'd1);

        // Full period: sequence repeats after 1023 chips, epoch once per period.
        T0 = 4'd2; T1 = 4'd6;
        do_reset(1);
        epochs = 0;
        for (int i = 0; i < 1023; i++) begin
            seq_a[i] = chip;
`ifdef CA_CODE_EPOCH_EN
            if (epoch) epochs++;
            if (i == 1) check("idx_after_one", {22'd0, chip_idx}, 32'd1);
            if (i == 1022) check("idx_last", {22'd0, chip_idx}, 32'd1022);
`endif
            step();
        end
`ifdef CA_CODE_EPOCH_EN
        check("idx_wrap", {22'd0, chip_idx}, 32'd0);
        check("epoch_wrap", {31'd0, epoch}, 32'd1);
`endif
        diff = 0;
        for (int i = 0; i < 1023; i++) begin
`ifdef CA_CODE_EPOCH_EN
            if (epoch) epochs++;
`endif
            if (chip !== seq_a[i]) diff++;
            step();
        end
        check("period_repeat_diffs", diff, 32'd0);
        got = 20'd0;
        for (int i = 0; i < 10; i++) got[19-i] = seq_a[i];
        check("period_first10", {12'd0, got}, {12'd0, 20'hC8000});
`ifdef CA_CODE_EPOCH_EN
        check("epoch_count", epochs, 32'd2);
`endif

        // Reset at chip 500 restarts the sequence on that edge.
        do_reset(1);
        for (int i = 0; i < 500; i++) step();
        do_reset(1);
`ifdef CA_CODE_EPOCH_EN
        check("midreset_idx", {22'd0, chip_idx}, 32'd0);
`endif
        collect(10, got);
        check("midreset_prn1", {12'd0, got}, {12'd0, 20'hC8000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
